cpu_mem_arbiter: RTL and testbench
==================================

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 i_request  in  1  instruction-fetch request pulse (read only).
REQ-004 i_address  in  32  fetch address, valid with i_request.
REQ-005 i_rdata  out  32  fetch read data, valid with i_valid.
REQ-006 i_valid  out  1  one-cycle pulse; fetch complete.
REQ-007 d_request  in  1  data request pulse from the ALU.
REQ-008 d_address, d_write, d_wstrb, d_wdata  in  32/1/4/32  data command, valid with d_request.
REQ-009 d_rdata  out  32  data read data, valid with d_valid.
REQ-010 d_valid  out  1  one-cycle pulse; load or store complete.
REQ-011 i_busy, d_busy  out  1 each  port has a held, unissued or outstanding transaction.
REQ-012 mem_request  out  1  one-cycle issue pulse to memory.
REQ-013 mem_address, mem_write, mem_wstrb, mem_wdata  out  32/1/4/32  issued command, valid with mem_request.
REQ-014 mem_rdata  in  32  memory read data.
REQ-015 mem_valid  in  1  one-cycle pulse; completes the outstanding transaction.
REQ-016 mem_busy  in  1  memory cannot accept an issue this cycle.
REQ-017 overflow  out  1  sticky protocol-error flag.

Function
REQ-018 Each port has a one-entry holding register (command + occupied bit); a request pulse is captured at the clock edge.
REQ-019 States: IDLE (nothing outstanding), WAIT_I (fetch outstanding), WAIT_D (data outstanding); at most one memory transaction outstanding.
REQ-020 Issue happens only from IDLE, with mem_busy=0 and ≥1 occupied holding register; mem_request is a registered one-cycle pulse in the cycle after the issue decision, carrying the chosen register's command; the chosen register is freed and state moves to WAIT_I/WAIT_D.
REQ-021 Minimum latency: request at cycle N in IDLE -> mem_request at N+1 -> earliest mem_valid at N+2 -> port valid at N+2.
REQ-022 Priority: data over fetch, except when the previous grant was data and fetch is pending, in which case fetch wins (alternation under contention; fetch never starved).
REQ-023 mem_busy=1 holds the issue; occupied registers and state are unchanged.
REQ-024 In WAIT_x, mem_valid drives x_valid=1 combinationally in the same cycle, x_rdata=mem_rdata, state -> IDLE; a new issue may start at that edge (back-to-back: next mem_request one cycle after mem_valid).
REQ-025 i_rdata/d_rdata pass mem_rdata through; value undefined when the matching valid is 0.
REQ-026 Stores also complete with d_valid; d_rdata is don't-care on stores.
REQ-027 mem_valid in IDLE is ignored (no port valid).
REQ-028 x_busy = holding register occupied OR state is WAIT_x.
REQ-029 Request arriving on a port whose holding register is occupied: dropped, and overflow set to 1 until reset.
REQ-030 Request arriving on a port in the same cycle that port's x_valid pulses: accepted (register is free); the valid refers to the old transaction.
REQ-031 Simultaneous i_request and d_request: both captured at the same edge.

Reset
REQ-032 On reset: state IDLE, both holding registers empty, last-grant = fetch, overflow=0, mem_request=0, i_valid=0, d_valid=0, i_busy=0, d_busy=0.
REQ-033 Reset mid-transaction abandons it; a later mem_valid is ignored per REQ-027; no port valid produced.

Verification
REQ-034 Single load: d_request, d_address=0x100, mem_valid 3 cycles after mem_request with mem_rdata=0xDEADBEEF -> d_valid one cycle, d_rdata=0xDEADBEEF, i_valid=0.
REQ-035 Contention: i_request and d_request at the same edge, then d_request again after d_valid -> issue order data, fetch, data.
REQ-036 mem_busy held 4 cycles while d pending -> no mem_request during busy; issue cycle after mem_busy falls; d_busy=1 throughout.
REQ-037 Store: d_write=1, d_wstrb=0b0100, d_wdata=0x00AB0000 -> mem_* carry identical values; d_valid on mem_valid.
REQ-038 Overflow: two d_request pulses while the first is held -> second dropped, only one mem_request, overflow=1 until reset.
REQ-039 Reset asserted in WAIT_D, mem_valid pulsed after release -> no d_valid, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-outstanding
// memory port. Each port has a one-entry holding register; requests that find
// an empty slot and a free memory are issued at the same edge they arrive.
module cpu_mem_arbiter #(
    localparam int unsigned ADDR_W = 32,
    localparam int unsigned DATA_W = 32,
    localparam int unsigned STRB_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_request,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_request,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_write,
    input  logic [STRB_W-1:0] d_wstrb,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              i_busy,
    output logic              d_busy,
    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    input  logic              mem_busy,
    output logic              overflow
);

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              write;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT_I = 2'd1;
    localparam logic [1:0] WAIT_D = 2'd2;

    logic [1:0] state_q, state_d;
    logic       i_occ_q, d_occ_q;
    cmd_t       i_cmd_q, d_cmd_q, mem_cmd_q;
    logic       last_d_q;
    logic       overflow_q;
    logic       mem_request_q;

    cmd_t i_in, d_in, i_cand, d_cand;
    logic completing, can_issue, i_pend, d_pend, grant_i, grant_d;

    // Incoming commands and the candidate each port offers this cycle
    always_comb begin
        i_in         = '0;
        i_in.address = i_address;
        d_in.address = d_address;
        d_in.write   = d_write;
        d_in.wstrb   = d_wstrb;
        d_in.wdata   = d_wdata;
        i_cand       = i_occ_q ? i_cmd_q : i_in;
        d_cand       = d_occ_q ? d_cmd_q : d_in;
    end

    // Arbitration: data first, but fetch wins after a data grant when both wait
    always_comb begin
        completing = mem_valid && (state_q != IDLE);
        can_issue  = ((state_q == IDLE) || completing) && !mem_busy;
        i_pend     = i_occ_q || i_request;
        d_pend     = d_occ_q || d_request;
        grant_d    = can_issue && d_pend && !(last_d_q && i_pend);
        grant_i    = can_issue && i_pend && !grant_d;
    end

    // Next-state logic for the outstanding-transaction tracker
    always_comb begin
        state_d = state_q;
        if (grant_d) begin
            state_d = WAIT_D;
        end else if (grant_i) begin
            state_d = WAIT_I;
        end else if (completing) begin
            state_d = IDLE;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding registers: capture when free and not issued straight through
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_occ_q <= 1'b0;
            d_occ_q <= 1'b0;
            i_cmd_q <= '0;
            d_cmd_q <= '0;
        end else begin
            if (i_occ_q) begin
                if (grant_i) i_occ_q <= 1'b0;
            end else if (i_request && !grant_i) begin
                i_occ_q <= 1'b1;
                i_cmd_q <= i_in;
            end
            if (d_occ_q) begin
                if (grant_d) d_occ_q <= 1'b0;
            end else if (d_request && !grant_d) begin
                d_occ_q <= 1'b1;
                d_cmd_q <= d_in;
            end
        end
    end

    // Registered issue pulse and command, plus last-grant memory
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_request_q <= 1'b0;
            mem_cmd_q     <= '0;
            last_d_q      <= 1'b0;
        end else begin
            mem_request_q <= grant_i || grant_d;
            if (grant_d) begin
                mem_cmd_q <= d_cand;
                last_d_q  <= 1'b1;
            end else if (grant_i) begin
                mem_cmd_q <= i_cand;
                last_d_q  <= 1'b0;
            end
        end
    end

    // Sticky flag: a request hit an already occupied holding register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if ((i_request && i_occ_q) || (d_request && d_occ_q)) begin
            overflow_q <= 1'b1;
        end
    end

    assign mem_request = mem_request_q;
    assign mem_address = mem_cmd_q.address;
    assign mem_write   = mem_cmd_q.write;
    assign mem_wstrb   = mem_cmd_q.wstrb;
    assign mem_wdata   = mem_cmd_q.wdata;
    assign overflow    = overflow_q;

    // Completion is reported in the same cycle memory answers
    assign i_valid = (state_q == WAIT_I) && mem_valid;
    assign d_valid = (state_q == WAIT_D) && mem_valid;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign i_busy  = i_occ_q || (state_q == WAIT_I);
    assign d_busy  = d_occ_q || (state_q == WAIT_D);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the port/memory rules.
module tb_cpu_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } cmd_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_request = 1'b0, d_request = 1'b0, d_write = 1'b0;
    logic [31:0] i_address = '0, d_address = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        mem_valid = 1'b0, mem_busy = 1'b0;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_wdata;
    logic        i_valid, d_valid, i_busy, d_busy, mem_request, mem_write, overflow;
    logic [3:0]  mem_wstrb;

    cpu_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .i_request(i_request), .i_address(i_address), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_request(d_request), .d_address(d_address), .d_write(d_write), .d_wstrb(d_wstrb),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
        .i_busy(i_busy), .d_busy(d_busy),
        .mem_request(mem_request), .mem_address(mem_address), .mem_write(mem_write),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .mem_busy(mem_busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: pending commands per port, which port owns memory, last grant
    cmd_t iq[$];
    cmd_t dq[$];
    int   outst;      // 0 none, 1 fetch, 2 data
    bit   last_d;
    bit   ovf;
    bit   e_req;
    cmd_t e_cmd;
    logic [31:0] issued[$];

    always @(negedge clock) if (mem_request === 1'b1) issued.push_back(mem_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        iq.delete();
        dq.delete();
        outst  = 0;
        last_d = 1'b0;
        ovf    = 1'b0;
        e_req  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        i_request = 1'b0; d_request = 1'b0; mem_valid = 1'b0; mem_busy = 1'b0;
        model_reset();
        #1;
        chk("rst_mem_request", 32'(mem_request), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_i_busy", 32'(i_busy), 32'd0);
        chk("rst_d_busy", 32'(d_busy), 32'd0);
        chk("rst_i_valid", 32'(i_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One clock: drive, check same-cycle completion, advance model, check edge results
    task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input cmd_t dc,
                        input bit mb, input bit mv, input logic [31:0] mr);
        cmd_t ic;
        bit   take_d;
        @(negedge clock);
        i_request = ir; i_address = ia;
        d_request = dr; d_address = dc.addr; d_write = dc.wr; d_wstrb = dc.strb; d_wdata = dc.wdata;
        mem_busy = mb; mem_valid = mv; mem_rdata = mr;
        #1;
        chk("i_valid", 32'(i_valid), 32'(mv && outst == 1));
        chk("d_valid", 32'(d_valid), 32'(mv && outst == 2));
        if (mv && outst == 1) chk("i_rdata", i_rdata, mr);
        if (mv && outst == 2 && !e_cmd.wr) chk("d_rdata", d_rdata, mr);
        if (mv) outst = 0;
        ic = '{addr: ia, wr: 1'b0, strb: 4'h0, wdata: 32'h0};
        if (ir) begin
            if (iq.size() == 0) iq.push_back(ic); else ovf = 1'b1;
        end
        if (dr) begin
            if (dq.size() == 0) dq.push_back(dc); else ovf = 1'b1;
        end
        e_req = 1'b0;
        if (outst == 0 && !mb && (iq.size() + dq.size()) > 0) begin
            take_d = (dq.size() > 0) && !(last_d && iq.size() > 0);
            if (take_d) begin
                e_cmd = dq.pop_front(); outst = 2; last_d = 1'b1;
            end else begin
                e_cmd = iq.pop_front(); outst = 1; last_d = 1'b0;
            end
            e_req = 1'b1;
        end
        @(posedge clock);
        #1;
        chk("mem_request", 32'(mem_request), 32'(e_req));
        if (e_req) begin
            chk("mem_address", mem_address, e_cmd.addr);
            chk("mem_write", 32'(mem_write), 32'(e_cmd.wr));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(e_cmd.strb));
            chk("mem_wdata", mem_wdata, e_cmd.wdata);
        end
        chk("i_busy", 32'(i_busy), 32'(iq.size() > 0 || outst == 1));
        chk("d_busy", 32'(d_busy), 32'(dq.size() > 0 || outst == 2));
        chk("overflow", 32'(overflow), 32'(ovf));
        i_request = 1'b0; d_request = 1'b0; mem_valid = 1'b0;
    endtask

    cmd_t nc = '0;

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, nc, 0, 0, 0);
    endtask

    initial begin
        cmd_t c;
        int   cnt;
        bit   mv;
        model_reset();
        reset = 1'b1;
        #12;

        // Single load, memory answers 3 cycles after mem_request
        do_reset();
        issued.delete();
        c = '{addr: 32'h100, wr: 1'b0, strb: 4'h0, wdata: 32'h0};
        step(0, 0, 1, c, 0, 0, 0);
        idle(3);
        step(0, 0, 0, nc, 0, 1, 32'hDEADBEEF);
        chk("load_issue_count", 32'(issued.size()), 32'd1);
        chk("load_issue_addr", issued[0], 32'h100);

        // Contention: data, then fetch, then the next data request
        do_reset();
        issued.delete();
        c = '{addr: 32'h2000, wr: 1'b0, strb: 4'h0, wdata: 32'h0};
        step(1, 32'h1000, 1, c, 0, 0, 0);
        idle(1);
        step(0, 0, 0, nc, 0, 1, 32'h11111111);
        idle(1);
        c.addr = 32'h3000;
        step(0, 0, 1, c, 0, 1, 32'h22222222);
        idle(1);
        step(0, 0, 0, nc, 0, 1, 32'h33333333);
        chk("order_count", 32'(issued.size()), 32'd3);
        chk("order_first", issued[0], 32'h2000);
        chk("order_second", issued[1], 32'h1000);
        chk("order_third", issued[2], 32'h3000);

        // mem_busy held four cycles with data pending
        do_reset();
        issued.delete();
        c = '{addr: 32'h44, wr: 1'b0, strb: 4'h0, wdata: 32'h0};
        step(0, 0, 1, c, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, nc, 1, 0, 0);
        chk("busy_no_issue", 32'(issued.size()), 32'd0);
        step(0, 0, 0, nc, 0, 0, 0);
        step(0, 0, 0, nc, 0, 1, 32'h5);

        // Store passes command through unchanged
        do_reset();
        c = '{addr: 32'h80, wr: 1'b1, strb: 4'b0100, wdata: 32'h00AB0000};
        step(0, 0, 1, c, 0, 0, 0);
        idle(1);
        step(0, 0, 0, nc, 0, 1, 32'h0);

        // Overflow: second request while first is held
        do_reset();
        issued.delete();
        c = '{addr: 32'h200, wr: 1'b0, strb: 4'h0, wdata: 32'h0};
        step(0, 0, 1, c, 1, 0, 0);
        c.addr = 32'h204;
        step(0, 0, 1, c, 1, 0, 0);
        step(0, 0, 0, nc, 0, 0, 0);
        idle(1);
        step(0, 0, 0, nc, 0, 1, 32'h9);
        idle(2);
        chk("ovf_issue_count", 32'(issued.size()), 32'd1);
        chk("ovf_issue_addr", issued[0], 32'h200);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();

        // Reset while data outstanding, stale mem_valid afterwards
        c = '{addr: 32'h300, wr: 1'b0, strb: 4'h0, wdata: 32'h0};
        step(0, 0, 1, c, 0, 0, 0);
        idle(1);
        do_reset();
        step(0, 0, 0, nc, 0, 1, 32'hCAFEF00D);
        idle(1);

        // Randomized traffic with a responding memory
        for (int blk = 0; blk < 20; blk++) begin
            do_reset();
            cnt = 0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                if (outst != 0) begin
                    mv = (cnt == 0);
                    if (cnt != 0) cnt--;
                end else begin
                    mv = ($urandom_range(0, 15) == 0);
                end
                c.addr  = $urandom;
                c.wr    = 1'($urandom_range(0, 1));
                c.strb  = 4'($urandom);
                c.wdata = $urandom;
                step($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0, c,
                     $urandom_range(0, 4) == 0, mv, $urandom);
                if (e_req) cnt = $urandom_range(1, 3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
